decoder_3x8_seq: RTL and testbench

DECODER_3X8_SEQ -- requirements
Module: decoder_3x8_seq

---
 rtl/decoder_3x8_seq.sv | 105 ++++++++++
 tb/tb_decoder_3x8_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_3x8_seq.sv
// 3-to-8 one-hot decoder behind one output register, with an auto-scan mode that walks a rotating one-hot code.
// Latency 1 cycle; in_ready drops while O is stalled by out_ready=0 or while scanning, and a presented code is never dropped.
module decoder_3x8_seq #(
   parameter int DWELL = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] I,
   input  logic       en,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       scan,
   output logic [7:0] O,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] xfer_cnt
);

   typedef enum logic [1:0] {NORM, SCAN_OUT, SCAN_GAP} state_t;

   localparam logic [3:0] DWELL_CNT = 4'(DWELL);

   state_t     state, state_nxt;
   logic [7:0] o_nxt;
   logic       out_valid_nxt;
   logic [3:0] gap_cnt, gap_nxt;
   logic       in_acc, out_acc;
   logic [7:0] o_rot;

   assign out_acc = out_valid & out_ready;
   assign in_acc  = in_valid & in_ready;
   assign o_rot   = {O[6:0], O[7]};

   // Held low during reset so nothing is accepted before the pipeline is live.
   always_comb begin
      in_ready = 1'b0;
      if (!rst && state == NORM)
         in_ready = !scan & (!out_valid | out_ready);
   end

   always_comb begin
      state_nxt     = state;
      o_nxt         = O;
      out_valid_nxt = out_valid;
      gap_nxt       = gap_cnt;
      unique case (state)
         NORM: begin
            // Scan only starts once any pending decode result has been taken.
            if (scan && (!out_valid || out_acc)) begin
               state_nxt     = SCAN_OUT;
               o_nxt         = 8'h01;
               out_valid_nxt = 1'b1;
            end else if (in_acc) begin
               out_valid_nxt = 1'b1;
               o_nxt         = en ? (8'h01 << I) : 8'h00;
            end else if (out_acc) begin
               out_valid_nxt = 1'b0;
            end
         end
         SCAN_OUT: begin
            if (out_acc) begin
               if (!scan) begin
                  state_nxt     = NORM;
                  out_valid_nxt = 1'b0;
               end else if (DWELL == 0) begin
                  o_nxt = o_rot;
               end else begin
                  state_nxt     = SCAN_GAP;
                  out_valid_nxt = 1'b0;
                  gap_nxt       = DWELL_CNT;
               end
            end
         end
         SCAN_GAP: begin
            gap_nxt = gap_cnt - 4'd1;
            if (!scan) begin
               state_nxt = NORM;
            end else if (gap_cnt == 4'd1) begin
               state_nxt     = SCAN_OUT;
               o_nxt         = o_rot;
               out_valid_nxt = 1'b1;
            end
         end
         default: state_nxt = NORM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= NORM;
         O         <= 8'h00;
         out_valid <= 1'b0;
         gap_cnt   <= 4'd0;
         xfer_cnt  <= 8'd0;
      end else begin
         state     <= state_nxt;
         O         <= o_nxt;
         out_valid <= out_valid_nxt;
         gap_cnt   <= gap_nxt;
         if (out_acc)
            xfer_cnt <= xfer_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Bench for decoder_3x8_seq: directed scenarios plus randomized traffic against a transaction-level model.
module tb_decoder_3x8_seq;
   localparam int DWELL = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] code;
   logic       en, in_valid, in_ready, scan, out_valid, out_ready;
   logic [7:0] dout, xfer_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Model: scanning flag, whether a code is presented, index of the lit bit (-1 = all zero), gap remaining, transfer count.
   bit m_scan, m_valid;
   int m_idx, m_gap, m_cnt;

   always #5 clk = ~clk;

   decoder_3x8_seq #(.DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .I(code), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .scan(scan), .O(dout), .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
   );

   function automatic logic [7:0] m_o();
      return (m_idx < 0) ? 8'h00 : 8'(1 << m_idx);
   endfunction

   function automatic bit m_in_ready();
      return !rst && !m_scan && !scan && (!m_valid || out_ready);
   endfunction

   function automatic void model_reset();
      m_scan = 0; m_valid = 0; m_idx = -1; m_gap = 0; m_cnt = 0;
   endfunction

   function automatic void model_step();
      bit out_acc, in_acc;
      out_acc = m_valid && out_ready;
      in_acc  = in_valid && m_in_ready();
      if (out_acc) m_cnt = (m_cnt + 1) % 256;
      if (!m_scan) begin
         if (scan && (!m_valid || out_acc)) begin
            m_scan = 1; m_valid = 1; m_idx = 0;
         end else if (in_acc) begin
            m_valid = 1; m_idx = en ? int'(code) : -1;
         end else if (out_acc) m_valid = 0;
      end else if (m_valid) begin
         if (out_acc) begin
            if (!scan) begin m_scan = 0; m_valid = 0; end
            else if (DWELL == 0) m_idx = (m_idx + 1) % 8;
            else begin m_valid = 0; m_gap = DWELL; end
         end
      end else begin
         if (!scan) m_scan = 0;
         else if (m_gap == 1) begin m_valid = 1; m_idx = (m_idx + 1) % 8; end
         else m_gap = m_gap - 1;
      end
   endfunction

   task automatic tick();
      if (rst) model_reset(); else model_step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1; code = 0; en = 0; in_valid = 0; scan = 0; out_ready = 0;
      model_reset();
      #3;
      n_checks++;
      if ({dout, out_valid, xfer_cnt, in_ready} !== {8'h00, 1'b0, 8'h00, 1'b0}) begin
         n_errors++; $display("FAIL reset_state: got O=%h v=%b cnt=%0d rdy=%b want 00 0 0 0", dout, out_valid, xfer_cnt, in_ready);
      end
      @(posedge clk); #1;
      rst = 0; #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_rdy: got %b want 1", in_ready); end
   endtask

   task automatic test_decode_sweep();
      out_ready = 1; in_valid = 1; en = 1;
      for (int i = 0; i < 8; i++) begin
         code = 3'(i);
         tick();
         n_checks++;
         if (dout !== 8'(1 << i) || out_valid !== 1'b1) begin
            n_errors++; $display("FAIL sweep_o%0d: got O=%h v=%b want %h 1", i, dout, out_valid, 8'(1 << i));
         end
      end
      in_valid = 0;
      tick();
      n_checks++;
      if (xfer_cnt !== 8'd8 || out_valid !== 1'b0) begin
         n_errors++; $display("FAIL sweep_cnt: got cnt=%0d v=%b want 8 0", xfer_cnt, out_valid);
      end
   endtask

   task automatic test_en_zero();
      int c0;
      c0 = m_cnt;
      code = 3'd5; en = 0; in_valid = 1; out_ready = 1;
      tick();
      n_checks++;
      if (dout !== 8'h00 || out_valid !== 1'b1) begin
         n_errors++; $display("FAIL en0_o: got O=%h v=%b want 00 1", dout, out_valid);
      end
      in_valid = 0;
      tick();
      n_checks++;
      if (xfer_cnt !== 8'(c0 + 1) || dout !== 8'h00) begin
         n_errors++; $display("FAIL en0_cnt: got cnt=%0d O=%h want %0d 00", xfer_cnt, dout, c0 + 1);
      end
   endtask

   task automatic test_backpressure();
      code = 3'd3; en = 1; in_valid = 1; out_ready = 0;
      tick();
      code = 3'd6;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if (in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_rdy%0d: got %b want 0", k, in_ready); end
         tick();
         n_checks++;
         if (dout !== 8'h08 || out_valid !== 1'b1) begin
            n_errors++; $display("FAIL bp_hold%0d: got O=%h v=%b want 08 1", k, dout, out_valid);
         end
      end
      out_ready = 1; #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_errors++; $display("FAIL bp_release_rdy: got %b want 1", in_ready); end
      tick();
      n_checks++;
      if (dout !== 8'h40 || out_valid !== 1'b1) begin
         n_errors++; $display("FAIL bp_next: got O=%h v=%b want 40 1", dout, out_valid);
      end
      in_valid = 0;
      tick();
   endtask

   task automatic test_scan();
      int nvalid;
      nvalid = 0;
      scan = 1; out_ready = 1; in_valid = 1; en = 1;
      for (int t = 1; t <= 30; t++) begin
         code = 3'($urandom_range(0, 7)); #1;
         n_checks++;
         if (in_ready !== 1'b0) begin n_errors++; $display("FAIL scan_rdy%0d: got %b want 0", t, in_ready); end
         tick();
         n_checks++;
         if (out_valid !== ((t - 1) % 3 == 0)) begin
            n_errors++; $display("FAIL scan_pulse%0d: got v=%b want %b", t, out_valid, ((t - 1) % 3 == 0));
         end
         if (out_valid) begin
            n_checks++;
            if (dout !== 8'(1 << (nvalid % 8))) begin
               n_errors++; $display("FAIL scan_code%0d: got %h want %h", nvalid, dout, 8'(1 << (nvalid % 8)));
            end
            nvalid++;
         end
      end
      in_valid = 0;
      n_checks++;
      if (nvalid != 10) begin n_errors++; $display("FAIL scan_count: got %0d want 10", nvalid); end
   endtask

   task automatic test_scan_stop();
      logic [7:0] held;
      for (int k = 0; k < 10 && !out_valid; k++) tick();
      n_checks++;
      if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stop_reach: got v=%b want 1", out_valid); end
      held = m_o();
      out_ready = 0; scan = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stop_rdy%0d: got %b want 0", k, in_ready); end
         tick();
         n_checks++;
         if (dout !== held || out_valid !== 1'b1) begin
            n_errors++; $display("FAIL stop_hold%0d: got O=%h v=%b want %h 1", k, dout, out_valid, held);
         end
      end
      out_ready = 1;
      tick();
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || dout !== held || in_ready !== 1'b1) begin
         n_errors++; $display("FAIL stop_norm: got v=%b O=%h rdy=%b want 0 %h 1", out_valid, dout, in_ready, held);
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = m_cnt;
      in_valid = 1; out_ready = 1; en = 1; scan = 0;
      for (int k = 0; k < 260; k++) begin
         code = 3'($urandom_range(0, 7));
         tick();
         n_checks++;
         if (dout !== 8'(1 << code) || out_valid !== 1'b1) begin
            n_errors++; $display("FAIL b2b_o%0d: got O=%h v=%b want %h 1", k, dout, out_valid, 8'(1 << code));
         end
      end
      in_valid = 0;
      tick();
      n_checks++;
      if (xfer_cnt !== 8'(c0 + 260)) begin
         n_errors++; $display("FAIL b2b_wrap: got %0d want %0d", xfer_cnt, (c0 + 260) % 256);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 9) == 0) scan = ~scan;
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 9) < 7);
         en        = ($urandom_range(0, 9) < 8);
         code      = 3'($urandom_range(0, 7));
         #1;
         n_checks++;
         if (in_ready !== m_in_ready()) begin
            n_errors++; $display("FAIL rand_rdy%0d: got %b want %b", k, in_ready, m_in_ready());
         end
         tick();
         n_checks++;
         if ({dout, out_valid, xfer_cnt} !== {m_o(), m_valid, 8'(m_cnt)} || !$onehot0(dout)) begin
            n_errors++; $display("FAIL rand_out%0d: got O=%h v=%b cnt=%0d want %h %b %0d", k, dout, out_valid, xfer_cnt, m_o(), m_valid, m_cnt);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      in_valid = 0; out_ready = 1; scan = 1;
      for (int k = 0; k < 40 && !(out_valid && dout == 8'h10); k++) tick();
      n_checks++;
      if (!(out_valid === 1'b1 && dout === 8'h10)) begin
         n_errors++; $display("FAIL rst_reach: got O=%h v=%b want 10 1", dout, out_valid);
      end
      rst = 1; model_reset(); #1;
      n_checks++;
      if ({dout, out_valid, xfer_cnt, in_ready} !== {8'h00, 1'b0, 8'h00, 1'b0}) begin
         n_errors++; $display("FAIL rst_async: got O=%h v=%b cnt=%0d rdy=%b want 00 0 0 0", dout, out_valid, xfer_cnt, in_ready);
      end
      scan = 0;
      tick(); tick();
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_errors++; $display("FAIL rst_hold: got rdy=%b v=%b want 0 0", in_ready, out_valid);
      end
      rst = 0; #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_release: got %b want 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_decode_sweep();
      test_en_zero();
      test_backpressure();
      test_scan();
      test_scan_stop();
      test_back_to_back();
      test_random();
      test_reset_mid_scan();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1, "timeout");
   end

endmodule
